osc_freq_meter: RTL and testbench
=================================

// Module: osc_freq_meter
// PURPOSE
//  Downstream consumer of the ring-oscillator stage. Drives the oscillator enable,
//  takes its clk-synchronised output, and counts rising edges over a fixed gate
//  window of clk cycles. Returns the count to the lab controller with a valid/ack
//  handshake. Used to characterise oscillator frequency relative to clk.
// PARAMETERS
//  GATE_CYCLES    1024  length of the measurement window, in clk cycles (>=1)
//  SETTLE_CYCLES  4     cycles with osc_en high before counting starts (>=1); flushes sync pipe
//  CNT_W          16    width of edge counter / result
// PORTS
//  clk          in   1      system clock; all logic on posedge
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      request a measurement; sampled only in IDLE
//  osc_q        in   1      oscillator output, already 2-FF synchronised to clk
//  osc_en       out  1      enable to the oscillator stage
//  busy         out  1      high in SETTLE, MEASURE, DONE
//  count        out  CNT_W  rising edges counted in last window
//  count_valid  out  1      count is final; held until accepted
//  count_ack    in   1      consumer accepts count (valid & ack = transfer)
//  count_sat    out  1      counter saturated during last window
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; osc_en=0, busy=0, count=0,
//   count_valid=0, count_sat=0, edge-detect reg q_d=0. Applies from any state.
//  Edge detect: q_d <= osc_q every cycle. rise = osc_q & ~q_d.
//  FSM: IDLE -> SETTLE -> MEASURE -> DONE -> IDLE.
//  IDLE: osc_en=0, busy=0. start=1 at edge T0 -> SETTLE.
//  SETTLE: osc_en=1, busy=1, lasts exactly SETTLE_CYCLES cycles (cycles 1..S).
//   Rises ignored. On exit: count<=0, count_sat<=0, gate counter<=0.
//  MEASURE: osc_en=1, lasts exactly GATE_CYCLES cycles (S+1..S+G). Each cycle
//   with rise=1 increments count; at 2^CNT_W-1 count holds and count_sat<=1.
//  DONE: entered at cycle S+G+1; osc_en=0, count_valid=1, count/count_sat
//   stable. count_valid & count_ack -> IDLE; count_valid=0 next cycle.
//   count and count_sat keep their values in IDLE until next SETTLE exit.
//  Latency: start at T0 -> osc_en=1 at T0+1 -> count_valid=1 at T0+S+G+1.
//  start ignored outside IDLE, including the DONE cycle where ack is taken;
//   a new start is required once back in IDLE.
//  count_ack outside DONE has no effect.
//  Max meaningful count is GATE_CYCLES/2 (osc_q sampled at clk); faster
//   oscillators alias — documented limitation, not detected.
//  Gate and settle counters sized by $clog2 of their parameters; no wrap
//   within a window.
// TESTING
//  1. rst_n=0 two cycles mid-anything -> all outputs 0, FSM IDLE next cycle.
//  2. S=4,G=16, osc_q toggles every clk from start -> count=8, sat=0,
//     count_valid rises exactly 21 cycles after start edge.
//  3. osc_q held 1 from before start -> count=0 (edge absorbed in SETTLE).
//  4. CNT_W=3,G=32, osc_q toggling each clk -> count=7, count_sat=1.
//  5. start pulsed during MEASURE and DONE ignored; count_ack held 0 for 10
//     cycles in DONE -> count_valid stays 1, count stable; ack -> IDLE, valid=0.
//  6. rst_n=0 mid-MEASURE -> osc_en=0 next cycle; new start gives clean count
//     matching scenario 2 (8).

Source files
------------

// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets the sync pipe settle,
// counts synchronised rising edges over a fixed clk gate window and hands the result over valid/ack.
module osc_freq_meter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_q,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  input  logic             count_ack,
  output logic             count_sat
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             q_d_r;
  logic [SW-1:0]    settle_cnt_r;
  logic [GW-1:0]    gate_cnt_r;
  logic [CNT_W-1:0] count_r;
  logic             count_sat_r;
  logic             osc_en_r;
  logic             busy_r;
  logic             count_valid_r;
  logic             rise_s;
  logic             settle_end_s;
  logic             gate_end_s;

  assign rise_s       = osc_q & ~q_d_r;
  assign settle_end_s = (settle_cnt_r == SETTLE_LAST);
  assign gate_end_s   = (gate_cnt_r == GATE_LAST);

  // Next-state decode for the measurement sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = SETTLE;
        else       state_nx_s = IDLE;
      end
      SETTLE: begin
        if (settle_end_s) state_nx_s = MEASURE;
        else              state_nx_s = SETTLE;
      end
      MEASURE: begin
        if (gate_end_s) state_nx_s = DONE;
        else            state_nx_s = MEASURE;
      end
      DONE: begin
        if (count_ack) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      q_d_r         <= 1'b0;
      osc_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      count_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      q_d_r         <= osc_q;
      osc_en_r      <= (state_nx_s == SETTLE) || (state_nx_s == MEASURE);
      busy_r        <= (state_nx_s != IDLE);
      count_valid_r <= (state_nx_s == DONE);
    end
  end

  // Settle/gate timers and the saturating edge counter; result persists through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt_r <= '0;
      gate_cnt_r   <= '0;
      count_r      <= '0;
      count_sat_r  <= 1'b0;
    end else begin
      if (state_r == SETTLE) settle_cnt_r <= settle_cnt_r + 1'b1;
      else                   settle_cnt_r <= '0;

      if ((state_r == SETTLE) && settle_end_s) begin
        count_r     <= '0;
        count_sat_r <= 1'b0;
        gate_cnt_r  <= '0;
      end else if (state_r == MEASURE) begin
        gate_cnt_r <= gate_cnt_r + 1'b1;
        if (rise_s) begin
          if (count_r == CNT_MAX) count_sat_r <= 1'b1;
          else                    count_r     <= count_r + 1'b1;
        end
      end
    end
  end

  assign osc_en      = osc_en_r;
  assign busy        = busy_r;
  assign count       = count_r;
  assign count_valid = count_valid_r;
  assign count_sat   = count_sat_r;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: a S=4/G=16/W=16 instance and a S=4/G=32/W=3
// instance for saturation; all outputs sampled on the falling clock edge.
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n, osc_q, tog_en;
  logic        start_a, ack_a, start_b, ack_b;
  logic        osc_en_a, busy_a, valid_a, sat_a;
  logic        osc_en_b, busy_b, valid_b, sat_b;
  logic [15:0] count_a;
  logic [2:0]  count_b;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  // Oscillator model: toggles once per clk when enabled.
  always @(negedge clk) if (tog_en) osc_q = ~osc_q;

  osc_freq_meter #(.GATE_CYCLES(16), .SETTLE_CYCLES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .osc_q(osc_q), .osc_en(osc_en_a),
    .busy(busy_a), .count(count_a), .count_valid(valid_a), .count_ack(ack_a),
    .count_sat(sat_a)
  );

  osc_freq_meter #(.GATE_CYCLES(32), .SETTLE_CYCLES(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .osc_q(osc_q), .osc_en(osc_en_b),
    .busy(busy_b), .count(count_b), .count_valid(valid_b), .count_ack(ack_b),
    .count_sat(sat_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One measurement: start, count negedges until valid, check result, then ack.
  // The i-th negedge after the start edge shows what posedge T0+i samples.
  task automatic run_meas(input bit sel, input bit toggle, input int exp_lat,
                          input int exp_cnt, input int exp_sat, input bit noisy);
    int lat;
    int held;
    lat = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tog_en = toggle;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (i == 1) check("osc_en_on", sel ? int'(osc_en_b) : int'(osc_en_a), 1);
      if (noisy && i == 10) start_a = 1'b1;
      if (sel ? valid_b : valid_a) begin
        lat = i;
        break;
      end
    end
    tog_en = 1'b0;
    check("latency", lat, exp_lat);
    check("count", sel ? int'(count_b) : int'(count_a), exp_cnt);
    check("sat", sel ? int'(sat_b) : int'(sat_a), exp_sat);
    check("osc_en_done", sel ? int'(osc_en_b) : int'(osc_en_a), 0);
    check("busy_done", sel ? int'(busy_b) : int'(busy_a), 1);
    if (noisy) begin
      for (int k = 0; k < 10; k++) begin
        start_a = (k == 3);
        @(negedge clk);
        held = int'(valid_a) + int'(busy_a);
        check("done_hold", held, 2);
        check("done_count", int'(count_a), exp_cnt);
      end
      start_a = 1'b1;
    end
    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge clk);
    ack_a   = 1'b0;
    ack_b   = 1'b0;
    start_a = 1'b0;
    check("valid_clr", sel ? int'(valid_b) : int'(valid_a), 0);
    check("busy_idle", sel ? int'(busy_b) : int'(busy_a), 0);
    @(negedge clk);
    check("no_restart", sel ? int'(busy_b) : int'(busy_a), 0);
    check("count_kept", sel ? int'(count_b) : int'(count_a), exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; osc_q = 1'b0; tog_en = 1'b0;
    start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", int'({osc_en_a, busy_a, valid_a, sat_a}) + int'(count_a), 0);
    check("rst_b", int'({osc_en_b, busy_b, valid_b, sat_b}) + int'(count_b), 0);
    rst_n = 1'b1;

    // 8 rises in a 16-cycle window, valid first seen by edge T0+21
    run_meas(1'b0, 1'b1, 21, 8, 0, 1'b0);
    // start pulses in MEASURE/DONE ignored, DONE held without ack
    run_meas(1'b0, 1'b1, 21, 8, 0, 1'b1);
    // static high input: its edge falls before the window
    osc_q = 1'b1;
    repeat (3) @(negedge clk);
    run_meas(1'b0, 1'b0, 21, 0, 0, 1'b0);
    // 16 rises into a 3-bit counter saturate at 7
    osc_q = 1'b0;
    run_meas(1'b1, 1'b1, 37, 7, 1, 1'b0);

    // reset in the middle of MEASURE
    @(negedge clk);
    start_a = 1'b1;
    tog_en  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_pre_rst", int'(busy_a), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("osc_en_rst", int'(osc_en_a), 0);
    @(negedge clk);
    check("mid_rst", int'({osc_en_a, busy_a, valid_a, sat_a}) + int'(count_a), 0);
    tog_en = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("idle_after_rst", int'(busy_a), 0);
    run_meas(1'b0, 1'b1, 21, 8, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
